// File: rtl/fnd_pkg.sv
// ============================================================================
// Module   : fnd_pkg
// Purpose  : Shared types and constants for the FND scan feeder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fnd_pkg;

    localparam int FND_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Double-dabble correction applied before each shift.
    function automatic bcd_t add3(input bcd_t d);
        return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Handshaked sequential binary-to-BCD converter (shift-add-3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_valid,
    input  logic [IN_W-1:0]         i_bin,
    output logic                    o_ready,
    output logic                    o_ovf,
    output logic                    o_done,
    output logic [FND_DIGITS*4-1:0] o_digits
);

    localparam logic [IN_W-1:0] c_bcd_max = IN_W'(BCD_MAX);
    localparam logic [3:0]      c_last    = 4'(IN_W - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IN_W-1:0]           r_bin;
    logic [FND_DIGITS*4-1:0]   r_scratch;
    logic [FND_DIGITS*4-1:0]   w_adj;
    logic [3:0]                r_cnt;
    logic                      r_ovf;
    logic                      w_accept;

    assign w_accept = (r_state == ST_IDLE) && i_valid;

    generate
        for (genvar gi = 0; gi < FND_DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = add3(r_scratch[4*gi +: 4]);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_valid) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (r_cnt == c_last) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_bin     <= (i_bin > c_bcd_max) ? c_bcd_max : i_bin;
            r_ovf     <= (i_bin > c_bcd_max);
            r_scratch <= '0;
            r_cnt     <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_scratch <= {w_adj[FND_DIGITS*4-2:0], r_bin[IN_W-1]};
            r_bin     <= {r_bin[IN_W-2:0], 1'b0};
            r_cnt     <= r_cnt + 4'd1;
        end
    end

    assign o_ready  = (r_state == ST_IDLE);
    assign o_done   = (r_state == ST_COMMIT);
    assign o_ovf    = r_ovf;
    assign o_digits = r_scratch;

endmodule

`default_nettype wire

// File: rtl/fnd_scan_feeder.sv
// ============================================================================
// Module   : fnd_scan_feeder
// Purpose  : Binary-to-BCD front end that scans four digits into an FND
//            decoder. Define FND_LEADING_ZERO_BLANK_EN to blank leading zeros.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fnd_scan_feeder
    import fnd_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int IN_W    = 14
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    input  logic [IN_W-1:0] i_bin,
    output logic            o_ready,
    input  logic            i_en,
    output logic [1:0]      o_digitSelect,
    output logic [3:0]      o_value,
    output logic            o_en,
    output logic            o_ovf
);

    localparam int c_pw = $clog2(CLK_DIV);
    localparam int c_sw = $clog2(FND_DIGITS);

    logic [c_pw-1:0]         r_presc;
    logic [c_sw-1:0]         r_scan;
    logic [FND_DIGITS*4-1:0] r_disp;
    logic [FND_DIGITS*4-1:0] w_digits;
    logic                    w_done;
    logic                    w_tick;
    logic                    w_blank;

    bin2bcd_seq #(
        .IN_W (IN_W)
    ) u_bin2bcd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_bin     (i_bin),
        .o_ready   (o_ready),
        .o_ovf     (o_ovf),
        .o_done    (w_done),
        .o_digits  (w_digits)
    );

    assign w_tick = (r_presc == c_pw'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc <= '0;
            r_scan  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
            if (w_tick) begin
                r_scan <= r_scan + c_sw'(1);
            end
        end
    end

    // Display is loaded only from a finished conversion, so the scan never tears.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_disp <= '0;
        end else if (w_done) begin
            r_disp <= w_digits;
        end
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        case (r_scan)
            2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
            2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
            2'd3:    w_blank = (r_disp[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    assign o_digitSelect = r_scan;
    assign o_value       = r_disp[{r_scan, 2'b00} +: 4];
    assign o_en          = i_en && !w_blank;

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_feeder.sv
// ============================================================================
// Module   : tb_fnd_scan_feeder
// Purpose  : Randomized self-checking bench for fnd_scan_feeder against a
//            decimal reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fnd_scan_feeder;

    localparam int CLK_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [13:0] bin;
    logic        ready;
    logic        en_in;
    logic [1:0]  sel;
    logic [3:0]  value;
    logic        en_out;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int n_edges;
    int exp_disp;
    int exp_ovf;

    fnd_scan_feeder #(
        .CLK_DIV (CLK_DIV),
        .IN_W    (14)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_valid       (valid),
        .i_bin         (bin),
        .o_ready       (ready),
        .i_en          (en_in),
        .o_digitSelect (sel),
        .o_value       (value),
        .o_en          (en_out),
        .o_ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges elapsed since reset release; drives the expected scan slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    function automatic int digit_of(input int v, input int k);
        return (v / pow10(k)) % 10;
    endfunction

    function automatic int blank_of(input int v, input int k);
`ifdef FND_LEADING_ZERO_BLANK_EN
        return (k != 0 && v < pow10(k)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_scan(input int ncyc);
        int es;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            es = (n_edges / CLK_DIV) % 4;
            check("sel", 32'(sel), 32'(es));
            check("value", 32'(value), 32'(digit_of(exp_disp, es)));
            check("en", 32'(en_out), 32'((en_in && blank_of(exp_disp, es) == 0) ? 1 : 0));
        end
    endtask

    task automatic wait_ready(input int limit, output int cnt);
        cnt = 0;
        while (!ready && cnt < limit) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic accept(input int v);
        int w;
        wait_ready(100, w);
        check("ready_before_load", 32'(ready), 32'd1);
        valid = 1'b1;
        bin   = 14'(v);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic finish_load(input int v, input int busy_so_far);
        int cnt;
        wait_ready(40, cnt);
        check("busy_cycles", 32'(cnt + busy_so_far), 32'd15);
        exp_disp = (v > 9999) ? 9999 : v;
        exp_ovf  = (v > 9999) ? 1 : 0;
        check("ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic load(input int v);
        accept(v);
        finish_load(v, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        valid    = 1'b0;
        bin      = '0;
        en_in    = 1'b1;
        exp_disp = 0;
        exp_ovf  = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_en", 32'(en_out), 32'd1);
        rst_n = 1'b1;
        check_scan(20);

        load(1234);
        check_scan(16);
        load(12000);
        check_scan(16);
        load(7);
        check_scan(16);

        // A second request during the conversion must be dropped.
        accept(1234);
        repeat (2) @(negedge clk);
        valid = 1'b1;
        bin   = 14'd5555;
        repeat (4) @(negedge clk);
        valid = 1'b0;
        finish_load(1234, 6);
        check_scan(16);

        // Reset in the middle of a conversion discards it.
        accept(8888);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_disp = 0;
        exp_ovf  = 0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_value", 32'(value), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_scan(16);

        en_in = 1'b0;
        check_scan(8);
        en_in = 1'b1;

        load(40);
        check_scan(16);
        load(0);
        check_scan(16);

        for (int t = 0; t < 12; t++) begin
            int v;
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 16383);
            endcase
            en_in = ($urandom_range(0, 3) != 0);
            load(v);
            check_scan(int'($urandom_range(8, 16)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fnd_scan_feeder.md
Name: fnd_scan_feeder

Overview:
- Sequential front-end that sits directly upstream of the BCD-to-FND decoder.
- Accepts a binary value (0..9999) over a valid/ready handshake and converts it to four BCD digits with a shift-add-3 engine.
- Holds the digits in a display register and time-multiplexes them, driving the decoder's digit-select, value and enable inputs at a programmable refresh rate.

Parameters:
- CLK_DIV, 100000, system clocks per digit slot (scan tick period); legal range >= 2.
- IN_W, 14, binary input width; fixed at 14 because 9999 < 2^14.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  i_bin carries a new value.
- i_bin  input  IN_W  unsigned binary value to display.
- o_ready  output  1  block can accept a value this cycle.
- i_en  input  1  global display enable; scanning continues while low.
- o_digitSelect  output  2  digit index to decoder; 0 = ones digit (rightmost).
- o_value  output  4  BCD digit for the selected position.
- o_en  output  1  decoder enable for the current slot.
- o_ovf  output  1  sticky flag: last accepted value was > 9999.

Behaviour:
- Reset: one clock, asynchronous active-low reset. Asserting i_reset_n low asynchronously forces the following; removal is synchronous to i_clk.
  - prescaler = 0, scan index = 0, display digits = 0000.
  - FSM = IDLE, o_ready = 1, o_ovf = 0.
  - o_digitSelect = 0, o_value = 0, o_en = i_en (combinational gate, see below).
- Reset mid-conversion discards the conversion; the display shows 0000.
- FSM states are IDLE, SHIFT and COMMIT. o_ready = (state == IDLE), registered.
- Accept: at the edge where i_valid && o_ready, the block:
  - latches min(i_bin, 9999);
  - sets o_ovf = (i_bin > 9999) and clears a prior o_ovf if the value is in range;
  - clears the BCD scratch register, loads shift count 0, and moves to SHIFT.
- SHIFT: each cycle, every scratch nibble >= 5 gets +3, then {scratch, bin} shifts left by 1.
  - After 14 shifts (count == 13 at the edge), the FSM goes to COMMIT.
- COMMIT: the 16-bit scratch is copied atomically into the display register and the FSM returns to IDLE.
- Latency: value accepted at edge 0 → display register and o_ready = 1 both update after edge 15. o_ready is low for exactly 15 cycles.
- i_valid while o_ready = 0 is ignored, with no queuing. The source must hold the value until the handshake completes.
- Display digits never tear: scan outputs read only the display register, never the scratch register.
- Prescaler counts 0..CLK_DIV-1 and wraps. A tick occurs at count == CLK_DIV-1.
  - On each tick the scan index increments modulo 4 (3 → 0).
  - Prescaler and scan are free-running, independent of the FSM and of i_en.
- o_digitSelect = scan index (registered).
- o_value = display digit[scan index], combinational from registers.
- o_en = i_en && !blank(scan index). blank() is always 0 unless the optional feature is enabled.
- Simultaneous tick and COMMIT: the new digit set is visible in the same cycle the new index appears.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k = 1..3) is blanked (o_en = 0 in its slot) when digits k..3 are all zero. Digit 0 is never blanked, so value 0 shows a single "0" and value 40 shows "40".
- Undefined: blank() = 0; all four digits are lit, including leading zeros.

Decomposition:
- Shared package fnd_pkg:
  - FND_DIGITS = 4;
  - BCD_MAX = 9999;
  - state typedef for IDLE/SHIFT/COMMIT;
  - 4-bit bcd_t typedef.
- One sub-module is natural: bin2bcd_seq, containing the FSM, scratch register, shift counter and handshake, with outputs done/digits.
- The top level keeps the prescaler, scan counter, display register, output mux and blank logic.

Test Plan:
- Reset, CLK_DIV = 4: hold i_reset_n low → o_ready = 1, o_ovf = 0, o_digitSelect = 0, o_value = 0. Release it → o_digitSelect steps 0,1,2,3,0 every 4 clocks.
- Load 1234 with i_valid for 1 cycle → o_ready low for 15 cycles. Then o_value reads 4,3,2,1 for o_digitSelect 0,1,2,3, and o_ovf = 0.
- Load 12000 → display 9999 and o_ovf = 1. Next load 7 → display 0007 and o_ovf = 0.
- Assert i_valid with 5555 during SHIFT of 1234 → it is ignored and the display ends at 1234. Then reset asserted at cycle 5 of a conversion of 8888 → display 0000 and o_ready = 1.
- Drive i_en = 0 for 8 clocks → o_en = 0 throughout while o_digitSelect keeps advancing.
- Load 40:
  - with FND_LEADING_ZERO_BLANK_EN → o_en = 1 for slots 0 and 1, 0 for slots 2 and 3;
  - without the macro → o_en = 1 for all slots;
  - load 0 with the macro → only slot 0 is enabled.
